// File: rtl/avg_pkg.sv
// Shared definitions for the averager front end (avg_batch_loader and friends).
// Optional Done watchdog is compiled in with `define AVG_LOADER_TIMEOUT_EN.
package avg_pkg;

  localparam int DATA_W         = 33;
  localparam int NUM_SAMPLES    = 8;   // averager has exactly eight operand inputs
  localparam int TIMEOUT_CYCLES = 32;  // Done watchdog limit (watchdog builds only)
  localparam int IDX_W          = 3;   // write index into the fill buffer

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } eng_state_e;

endpackage

// File: rtl/avg_batch_loader_if.sv
// Bus bundle for avg_batch_loader: sample stream in, result stream out, and the
// operand/handshake wires to the 8-input averager.
// master = loader side, slave = environment (source, sink and averager).
interface avg_batch_loader_if #(parameter int DATA_W = avg_pkg::DATA_W);

  // sample stream
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] sa_in;

  // averager side
  logic              Start;
  logic [DATA_W-1:0] a, b, c, d, e, f, g, h;
  logic [DATA_W-1:0] sa;
  logic              Done;
  logic [DATA_W-1:0] avg;

  // result stream
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              err;

  modport master (
    input  in_valid, in_data, sa_in, Done, avg, out_ready,
    output in_ready, Start, a, b, c, d, e, f, g, h, sa, out_valid, out_data, err
  );

  modport slave (
    output in_valid, in_data, sa_in, Done, avg, out_ready,
    input  in_ready, Start, a, b, c, d, e, f, g, h, sa, out_valid, out_data, err
  );

endinterface

// File: rtl/avg_fill_buffer.sv
// Shadow fill buffer: collects eight samples plus a shift amount while the
// engine may still be busy with the previous batch. clr_i empties it on copy.
module avg_fill_buffer
  import avg_pkg::*;
#(
  parameter int DATA_W = avg_pkg::DATA_W
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                valid_i,
  input  logic [DATA_W-1:0]                   data_i,
  input  logic [DATA_W-1:0]                   sa_i,
  input  logic                                clr_i,
  output logic                                ready_o,
  output logic                                full_o,
  output logic [NUM_SAMPLES-1:0][DATA_W-1:0]  data_o,
  output logic [DATA_W-1:0]                   sa_o
);

  logic [NUM_SAMPLES-1:0][DATA_W-1:0] mem_q;
  logic [DATA_W-1:0]                  sa_q;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               full_q;
  logic                               acc;

  assign acc     = valid_i && !full_q;
  assign idx_d   = idx_q + IDX_W'(1);  // natural 3-bit wrap 7 -> 0
  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = mem_q;
  assign sa_o    = sa_q;

  // Write accepted samples in order; the eighth one closes the batch and
  // captures its shift amount. A copy (clr_i) only happens while full, so it
  // can never coincide with an acceptance.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem_q  <= '0;
      sa_q   <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (clr_i) begin
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (acc) begin
      mem_q[idx_q] <= data_i;
      idx_q        <= idx_d;
      if (idx_q == IDX_W'(NUM_SAMPLES-1)) begin
        full_q <= 1'b1;
        sa_q   <= sa_i;
      end
    end
  end

endmodule

// File: rtl/avg_batch_loader.sv
// avg_batch_loader: packs eight streamed samples into the averager operands,
// pulses Start, waits for Done and offers avg on a valid/ready result stream.
// Optional macro AVG_LOADER_TIMEOUT_EN adds a Done watchdog with sticky err.
module avg_batch_loader
  import avg_pkg::*;
#(
  parameter int DATA_W = avg_pkg::DATA_W
) (
  input logic              Clk,
  input logic              Rst,
  avg_batch_loader_if.master bus
);

  logic                               full;
  logic                               launch;
  logic [NUM_SAMPLES-1:0][DATA_W-1:0] fill_data;
  logic [DATA_W-1:0]                  fill_sa;

  eng_state_e                         state_q;
  logic                               start_q;
  logic [NUM_SAMPLES-1:0][DATA_W-1:0] ops_q;
  logic [DATA_W-1:0]                  sa_q;
  logic                               res_valid_q;
  logic [DATA_W-1:0]                  out_data_q;
`ifdef AVG_LOADER_TIMEOUT_EN
  logic                               err_q;
  logic [7:0]                         cnt_q;
`endif

  // Launch looks at the registered res_valid, so a result handshake in the
  // same cycle as full delays the copy by one cycle.
  assign launch = (state_q == IDLE) && full && !res_valid_q;

  avg_fill_buffer #(.DATA_W(DATA_W)) u_fill (
    .Clk     (Clk),
    .Rst     (Rst),
    .valid_i (bus.in_valid),
    .data_i  (bus.in_data),
    .sa_i    (bus.sa_in),
    .clr_i   (launch),
    .ready_o (bus.in_ready),
    .full_o  (full),
    .data_o  (fill_data),
    .sa_o    (fill_sa)
  );

  // Engine: copy operands and fire Start, wait for Done, hold the result
  // until the sink takes it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      ops_q       <= '0;
      sa_q        <= '0;
      res_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef AVG_LOADER_TIMEOUT_EN
      err_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      if (res_valid_q && bus.out_ready)
        res_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (launch) begin
            ops_q   <= fill_data;
            sa_q    <= fill_sa;
            start_q <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= BUSY;
`ifdef AVG_LOADER_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        BUSY: begin
          if (bus.Done) begin
            out_data_q  <= bus.avg;
            res_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
`ifdef AVG_LOADER_TIMEOUT_EN
          // err lands exactly TIMEOUT_CYCLES edges after BUSY entry
          else if (cnt_q == 8'(TIMEOUT_CYCLES-1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Start     = start_q;
  assign bus.a         = ops_q[0];
  assign bus.b         = ops_q[1];
  assign bus.c         = ops_q[2];
  assign bus.d         = ops_q[3];
  assign bus.e         = ops_q[4];
  assign bus.f         = ops_q[5];
  assign bus.g         = ops_q[6];
  assign bus.h         = ops_q[7];
  assign bus.sa        = sa_q;
  assign bus.out_valid = res_valid_q;
  assign bus.out_data  = out_data_q;
`ifdef AVG_LOADER_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
